axi_stream_fifo: RTL and testbench

AXI_STREAM_FIFO -- requirements
Module: axi_stream_fifo

---
 rtl/axi_stream_fifo.sv | 77 +++++++
 tb/tb_axi_stream_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_fifo.sv
// First-word-fall-through AXI-Stream FIFO with beat and packet occupancy counters.
// Full/empty come from the registered count only, so there is no bypass or pass-through path.
module axi_stream_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic [DATA_WIDTH-1:0]       s_tdata,
   input  logic                        s_tlast,
   input  logic                        s_tvalid,
   output logic                        s_tready,
   output logic [DATA_WIDTH-1:0]       m_tdata,
   output logic                        m_tlast,
   output logic                        m_tvalid,
   input  logic                        m_tready,
   output logic [$clog2(DEPTH):0]      count,
   output logic [$clog2(DEPTH):0]      pkt_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH:0] mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [DATA_WIDTH:0] head;
   logic                wr;
   logic                rd;
   logic                pkt_inc;
   logic                pkt_dec;

   assign s_tready = (count != CW'(DEPTH));
   assign m_tvalid = (count != '0);
   assign head     = mem[rd_ptr];
   assign m_tdata  = head[DATA_WIDTH-1:0];
   assign m_tlast  = head[DATA_WIDTH];

   // Handshakes seen while reset is asserted must not move any state.
   assign wr      = s_tvalid & s_tready & ~areset;
   assign rd      = m_tvalid & m_tready & ~areset;
   assign pkt_inc = wr & s_tlast;
   assign pkt_dec = rd & m_tlast;

   always_ff @(posedge aclk) begin
      if (wr) begin
         mem[wr_ptr] <= {s_tlast, s_tdata};
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         pkt_count <= '0;
      end else begin
         if (wr) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (wr && !rd) begin
            count <= count + CW'(1);
         end else if (rd && !wr) begin
            count <= count - CW'(1);
         end
         if (pkt_inc && !pkt_dec) begin
            pkt_count <= pkt_count + CW'(1);
         end else if (pkt_dec && !pkt_inc) begin
            pkt_count <= pkt_count - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_axi_stream_fifo.sv
// Bench for axi_stream_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations on the delivered beat stream.
module tb_axi_stream_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          aclk = 1'b0;
   logic          areset;
   logic [DW-1:0] s_tdata;
   logic          s_tlast;
   logic          s_tvalid;
   logic          s_tready;
   logic [DW-1:0] m_tdata;
   logic          m_tlast;
   logic          m_tvalid;
   logic          m_tready;
   logic [CW-1:0] count;
   logic [CW-1:0] pkt_count;

   axi_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .aclk      (aclk),
      .areset    (areset),
      .s_tdata   (s_tdata),
      .s_tlast   (s_tlast),
      .s_tvalid  (s_tvalid),
      .s_tready  (s_tready),
      .m_tdata   (m_tdata),
      .m_tlast   (m_tlast),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .count     (count),
      .pkt_count (pkt_count)
   );

   always #5 aclk = ~aclk;

   int          n_cmp = 0;
   int          n_bad = 0;
   bit          chk_en = 0;
   logic [DW:0] model_q [$];
   logic [DW:0] dut_log [$];
   int          max_cnt = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: an ideal FIFO with capacity DEPTH, updated from the inputs at each edge.
   always @(posedge aclk) begin
      bit w, r;
      if (areset) begin
         model_q.delete();
      end else begin
         w = s_tvalid && (model_q.size() != DEPTH);
         r = m_tready && (model_q.size() != 0);
         if (r) void'(model_q.pop_front());
         if (w) model_q.push_back({s_tlast, s_tdata});
      end
   end

   // Beats actually delivered by the DUT.
   always @(posedge aclk) begin
      if (!areset && m_tvalid === 1'b1 && m_tready === 1'b1)
         dut_log.push_back({m_tlast, m_tdata});
   end

   always @(negedge aclk) begin
      int lasts;
      if (chk_en) begin
         lasts = 0;
         foreach (model_q[i]) if (model_q[i][DW]) lasts++;
         chk("s_tready", s_tready, model_q.size() != DEPTH);
         chk("m_tvalid", m_tvalid, model_q.size() != 0);
         chk("count", count, model_q.size());
         chk("pkt_count", pkt_count, lasts);
         if (model_q.size() != 0) begin
            chk("m_tdata", m_tdata, model_q[0][DW-1:0]);
            chk("m_tlast", m_tlast, model_q[0][DW]);
         end
         if (int'(count) > max_cnt) max_cnt = int'(count);
      end
   end

   task automatic push_beats(input logic [DW-1:0] base, input int n, input int last_idx);
      for (int i = 0; i < n; i++) begin
         @(negedge aclk);
         s_tvalid = 1'b1;
         s_tdata  = base + DW'(i);
         s_tlast  = (i == last_idx);
      end
      @(negedge aclk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      #1;
   endtask

   task automatic drain(input int n);
      m_tready = 1'b1;
      repeat (n) @(negedge aclk);
      m_tready = 1'b0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      logic [DW-1:0] held_d;
      areset   = 1'b1;
      s_tvalid = 1'b1;
      s_tdata  = 32'h0bad;
      s_tlast  = 1'b1;
      m_tready = 1'b1;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      chk_en = 1;
      #1;
      chk("rst_s_tready", s_tready, 1);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_count", count, 0);
      chk("rst_pkt_count", pkt_count, 0);
      areset   = 1'b0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      m_tready = 1'b0;
      @(negedge aclk); #1;
      chk("post_rst_s_tready", s_tready, 1);
      chk("post_rst_m_tvalid", m_tvalid, 0);

      // Fill then drain.
      push_beats(32'hdeadbeef, 8, 7);
      chk("fill_count", count, 8);
      chk("fill_s_tready", s_tready, 0);
      chk("fill_pkt_count", pkt_count, 1);
      chk("fill_head", m_tdata, 32'hdeadbeef);
      dut_log.delete();
      drain(8);
      chk("drain_count", count, 0);
      chk("drain_n", dut_log.size(), 8);
      for (int i = 0; i < 8 && i < dut_log.size(); i++) begin
         chk("drain_data", dut_log[i][DW-1:0], 32'hdeadbeef + i);
         chk("drain_last", dut_log[i][DW], i == 7);
      end

      // Full with simultaneous write and read.
      push_beats(32'h100, 8, -1);
      dut_log.delete();
      s_tvalid = 1'b1;
      s_tdata  = 32'h200;
      m_tready = 1'b1;
      @(negedge aclk); #1;
      chk("full_rw_count", count, 7);
      chk("full_rw_reads", dut_log.size(), 1);
      m_tready = 1'b0;
      @(negedge aclk); #1;
      chk("full_w_count", count, 8);
      s_tvalid = 1'b0;
      drain(8);
      chk("full_drain_n", dut_log.size(), 9);
      if (dut_log.size() == 9) begin
         chk("full_first", dut_log[0][DW-1:0], 32'h100);
         chk("full_tail", dut_log[8][DW-1:0], 32'h200);
         chk("full_mid", dut_log[7][DW-1:0], 32'h107);
      end

      // Empty with simultaneous write and read: no bypass.
      dut_log.delete();
      s_tvalid = 1'b1;
      s_tdata  = 32'h11;
      m_tready = 1'b1;
      @(negedge aclk); #1;
      chk("empty_rw_reads", dut_log.size(), 0);
      chk("empty_rw_m_tvalid", m_tvalid, 1);
      chk("empty_rw_m_tdata", m_tdata, 32'h11);
      chk("empty_rw_count", count, 1);
      s_tvalid = 1'b0;
      @(negedge aclk); #1;
      m_tready = 1'b0;
      chk("empty_rw_drained", count, 0);
      chk("empty_rw_beat", dut_log.size() == 1 ? dut_log[0][DW-1:0] : 32'hffffffff, 32'h11);

      // Backpressure stability.
      push_beats(32'habc, 1, 0);
      for (int c = 0; c < 5; c++) begin
         @(negedge aclk); #1;
         chk("hold_m_tdata", m_tdata, 32'habc);
         chk("hold_m_tlast", m_tlast, 1);
         chk("hold_m_tvalid", m_tvalid, 1);
      end
      drain(1);

      // Streaming with wrap-around and alternating m_tready.
      dut_log.delete();
      max_cnt = 0;
      sent    = 0;
      for (int c = 0; c < 300 && dut_log.size() < 20; c++) begin
         @(negedge aclk);
         m_tready = (c % 2 == 0);
         if (sent < 20) begin
            s_tvalid = 1'b1;
            s_tdata  = DW'(sent);
            s_tlast  = (sent == 19);
            if (s_tready) sent++;
         end else begin
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
         end
      end
      @(negedge aclk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      m_tready = 1'b0;
      #1;
      chk("wrap_n", dut_log.size(), 20);
      for (int i = 0; i < 20 && i < dut_log.size(); i++)
         chk("wrap_beat", dut_log[i][DW-1:0], i);
      if (dut_log.size() == 20) chk("wrap_last", dut_log[19][DW], 1);
      chk("wrap_max_count", max_cnt, 8);
      chk("wrap_end_count", count, 0);

      // Reset mid-stream discards stored beats and ignores the reset-cycle handshake.
      push_beats(32'h300, 3, 1);
      chk("pre_rst_count", count, 3);
      chk("pre_rst_pkt", pkt_count, 1);
      dut_log.delete();
      areset   = 1'b1;
      s_tvalid = 1'b1;
      s_tdata  = 32'h55;
      m_tready = 1'b1;
      @(negedge aclk);
      areset   = 1'b0;
      s_tvalid = 1'b0;
      #1;
      chk("mid_rst_count", count, 0);
      chk("mid_rst_pkt", pkt_count, 0);
      chk("mid_rst_m_tvalid", m_tvalid, 0);
      chk("mid_rst_s_tready", s_tready, 1);
      repeat (3) @(negedge aclk);
      #1;
      chk("mid_rst_nothing_out", dut_log.size(), 0);
      chk("mid_rst_still_empty", count, 0);
      m_tready = 1'b0;

      @(negedge aclk);
      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
